// File: rtl/uart_tx.sv
// uart_tx: drains bytes from a FIFO read port and sends them LSB-first as 8N1 frames on tx_o.
// Latency: pop in the first IDLE cycle fifo_ready_i is high, FETCH next cycle, start bit the cycle after.
// Backpressure: pops only from IDLE with fifo_ready_i high, one byte per frame; never underflows the FIFO.
//
// Ports:
//   clock, reset        sole clock; asynchronous active-high reset
//   fifo_read_o         one-cycle pop request (FIFO read_i)
//   fifo_data_i         head-of-FIFO data, latched in FETCH (FIFO read_data_o)
//   fifo_ready_i        FIFO non-empty flag (FIFO read_ready_o)
//   tx_o                serial line, idles high
//   busy_o              high from FETCH until the end of the stop bit
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.

module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int CLOCK_DIV = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 fifo_read_o,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  input  logic                 fifo_ready_i,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int BAUD_W = $clog2(CLOCK_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLOCK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BAUD_W-1:0]    baud_q,  baud_d;
  logic [BIT_W-1:0]     bit_q,   bit_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q,   par_d;
`endif

  logic baud_done;
  assign baud_done = (baud_q == '0);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_ready_i) state_d = FETCH;
      end
      FETCH: begin
        // Data is captured here once; later changes on fifo_data_i are ignored.
        shift_d = fifo_data_i;
        bit_d   = '0;
        baud_d  = BAUD_MAX;
`ifdef UART_TX_PARITY_EN
        // Parity is taken from the unshifted byte since the shift register is consumed.
        par_d   = ^fifo_data_i;
`endif
        state_d = START;
      end
      START: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          state_d = STOP;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          state_d = IDLE;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_o        = 1'b1;
    fifo_read_o = 1'b0;
    busy_o      = (state_q != IDLE);
    case (state_q)
      // Gated by reset so a pending ready flag cannot pop a byte while held in reset.
      IDLE:   fifo_read_o = fifo_ready_i & ~reset;
      START:  tx_o = 1'b0;
      DATA:   tx_o = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_o = par_q;
`endif
      default: tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int DB = 8;
  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DB + 3;
`else
  localparam int FRAME_BITS = DB + 2;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CD;

  logic          clock;
  logic          reset;
  logic          fifo_read_o;
  logic [DB-1:0] fifo_data_i;
  logic          fifo_ready_i;
  logic          tx_o;
  logic          busy_o;

  uart_tx #(.DATA_BITS(DB), .CLOCK_DIV(CD)) dut (
    .clock        (clock),
    .reset        (reset),
    .fifo_read_o  (fifo_read_o),
    .fifo_data_i  (fifo_data_i),
    .fifo_ready_i (fifo_ready_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [DB-1:0] dat;
    logic          par;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FRAME_BITS-1:0] mk_line(input logic [DB-1:0] dat, input logic par);
    logic [FRAME_BITS-1:0] l;
`ifdef UART_TX_PARITY_EN
    l = {1'b1, par, dat, 1'b0};
`else
    l = {1'b1, dat, 1'b0} | {FRAME_BITS{1'b0 & par}};
`endif
    return l;
  endfunction

  function automatic logic [FRAME_CYC-1:0] expand(input logic [FRAME_BITS-1:0] line);
    logic [FRAME_CYC-1:0] r;
    for (int c = 0; c < FRAME_CYC; c++) r[c] = line[c / CD];
    return r;
  endfunction

  // FIFO model and scoreboard state
  vec_t                  fifo_q[$];
  logic [FRAME_BITS-1:0] exp_q[$];
  int                    pop_log[$];
  logic [DB-1:0]         junk_dat = '0;
  logic                  just_popped = 1'b0;

  int                    cyc = 0;
  int                    pops = 0;
  int                    frames = 0;
  int                    last_pop_cyc = 0;
  int                    last_end_cyc = 0;
  int                    last_gap = 0;
  int                    rise_cyc = 0;
  logic                  rise_pending = 1'b0;
  logic                  prev_ready = 1'b0;
  logic                  in_frame = 1'b0;
  int                    fidx = 0;
  logic                  busy_ok = 1'b1;
  logic [FRAME_CYC-1:0]  obs = '0;
  logic [FRAME_CYC-1:0]  last_obs = '0;

  // FIFO driver: read data is held for the FETCH cycle after a pop, ready lags the queue by a cycle.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (just_popped) just_popped = 1'b0;
      else fifo_data_i = (fifo_q.size() > 0) ? fifo_q[0].dat : junk_dat;
      fifo_ready_i = (fifo_q.size() > 0);
    end
  end

  // Monitor: pops, latencies and cycle-exact frame capture
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        in_frame     = 1'b0;
        exp_q.delete();
        rise_pending = 1'b0;
        prev_ready   = fifo_ready_i;
      end else begin
        if (fifo_ready_i && !prev_ready && !busy_o) begin
          rise_pending = 1'b1;
          rise_cyc     = cyc;
        end
        prev_ready = fifo_ready_i;
        if (fifo_read_o) begin
          check("pop_needs_ready", 64'(fifo_ready_i), 64'(1));
          check("busy_low_at_pop", 64'(busy_o), 64'(0));
          if (rise_pending) check("pop_latency", 64'(cyc - rise_cyc), 64'(0));
          rise_pending = 1'b0;
          pops++;
          pop_log.push_back(cyc);
          last_pop_cyc = cyc;
          if (fifo_q.size() > 0) begin
            exp_q.push_back(mk_line(fifo_q[0].dat, fifo_q[0].par));
            void'(fifo_q.pop_front());
            just_popped = 1'b1;
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_from_empty: pop at cycle %0d, model queue size 0", cyc);
          end
        end
        if (!in_frame && tx_o == 1'b0) begin
          in_frame = 1'b1;
          fidx     = 0;
          busy_ok  = 1'b1;
          obs      = '0;
          check("start_latency", 64'(cyc - last_pop_cyc), 64'(2));
          last_gap = cyc - last_end_cyc - 1;
        end
        if (in_frame) begin
          obs[fidx] = tx_o;
          if (!busy_o) busy_ok = 1'b0;
          fidx++;
          if (fidx == FRAME_CYC) begin
            in_frame     = 1'b0;
            last_end_cyc = cyc;
            last_obs     = obs;
            frames++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame: line %0h, no byte expected", obs);
            end else begin
              check("frame_line", 64'(obs), 64'(expand(exp_q.pop_front())));
            end
            check("busy_in_frame", 64'(busy_ok), 64'(1));
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [DB-1:0] dat, input logic par);
    vec_t v;
    v.dat = dat;
    v.par = par;
    fifo_q.push_back(v);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames < target && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    check("frame_timeout", 64'(frames >= target), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   p0, f0, k, reads, lows, busys;
    logic found;

    vecs[0] = '{dat: 8'h5A, par: 1'b0};
    vecs[1] = '{dat: 8'h01, par: 1'b1};
    vecs[2] = '{dat: 8'h80, par: 1'b1};
    vecs[3] = '{dat: 8'h07, par: 1'b1};
    vecs[4] = '{dat: 8'h03, par: 1'b0};
    vecs[5] = '{dat: 8'h3C, par: 1'b0};

    reset        = 1'b1;
    fifo_ready_i = 1'b0;
    fifo_data_i  = '0;

    // Reset state
    #2;
    check("rst_tx", 64'(tx_o), 64'(1));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_read", 64'(fifo_read_o), 64'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;

    // Single byte 0xA5
    push_byte(8'hA5, 1'b0);
    wait_frames(1, 200);
    check("a5_pops", 64'(pops), 64'(1));
`ifndef UART_TX_PARITY_EN
    check("a5_literal", 64'(last_obs), 64'h00_FF0F00F0F0);
`endif
    repeat (5) @(negedge clock);
    #1;

    // Back-to-back 0x00 then 0xFF
    p0 = pops;
    f0 = frames;
    push_byte(8'h00, 1'b0);
    push_byte(8'hFF, 1'b0);
    wait_frames(f0 + 2, 300);
    check("b2b_pops", 64'(pops - p0), 64'(2));
    check("b2b_gap", 64'(last_gap), 64'(2));
    if (pop_log.size() >= 2)
      check("b2b_total", 64'(last_end_cyc - pop_log[pop_log.size() - 2] + 1), 64'(2 * (FRAME_CYC + 2)));
    repeat (4) @(negedge clock);
    #1;

    // Table-driven bytes with varying idle gaps
    for (int i = 0; i < 6; i++) begin
      f0 = frames;
      push_byte(vecs[i].dat, vecs[i].par);
      wait_frames(f0 + 1, 200);
`ifdef UART_TX_PARITY_EN
      check("parity_bit", 64'(last_obs[(DB + 1) * CD]), 64'(vecs[i].par));
`endif
      check("stop_bit", 64'(last_obs[FRAME_CYC - 1]), 64'(1));
      repeat ($urandom_range(5)) @(negedge clock);
      #1;
    end

    // Data hold: head changes to 0x3C after FETCH while 0xC3 is on the line
    junk_dat = 8'h3C;
    f0 = frames;
    push_byte(8'hC3, 1'b0);
    wait_frames(f0 + 1, 200);
    repeat (3) @(negedge clock);
    #1;

    // Empty FIFO for 100 cycles
    reads = 0;
    lows  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (fifo_read_o) reads++;
      if (!tx_o) lows++;
    end
    check("empty_reads", 64'(reads), 64'(0));
    check("empty_tx_low", 64'(lows), 64'(0));

    // Reset mid-DATA while the line is low
    f0 = frames;
    push_byte(8'hA5, 1'b0);
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      @(negedge clock);
      #1;
      k++;
      if (in_frame && fidx > CD && fidx < (DB + 1) * CD && tx_o == 1'b0) found = 1'b1;
    end
    check("reset_window_found", 64'(found), 64'(1));
    reset        = 1'b1;
    fifo_ready_i = 1'b1;
    #1;
    check("midrst_tx", 64'(tx_o), 64'(1));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_read", 64'(fifo_read_o), 64'(0));
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    reads = 0;
    lows  = 0;
    busys = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      #1;
      if (fifo_read_o) reads++;
      if (!tx_o) lows++;
      if (busy_o) busys++;
    end
    check("postrst_reads", 64'(reads), 64'(0));
    check("postrst_tx_low", 64'(lows), 64'(0));
    check("postrst_busy", 64'(busys), 64'(0));
    check("postrst_no_frame", 64'(frames - f0), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
